addsub_seq_ctrl: RTL

- Multi-byte add/subtract sequencer built around the team's existing 8-bit datapath:
  - the 8-bit conditional inverter (m=1 outputs ~b, m=0 passes b);
  - an 8-bit ripple adder with carry in and carry out.
- Takes NBYTES-wide operands through a valid/ready handshake.
- Streams one byte slice per cycle through the shared datapath, LSB first, and drives the inverter mode and the adder carry-in.
- Collects the sum bytes and returns the result, carry and flags through a valid/ready handshake.

---
 rtl/addsub_seq_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// Multi-byte add/subtract sequencer: streams LSB-first byte slices of the
// latched operands through an external 8-bit inverter + ripple adder.
module addsub_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic [7:0]          dp_a,
  output logic [7:0]          dp_b,
  output logic                dp_m,
  output logic                dp_cin,
  input  logic [7:0]          dp_sum,
  input  logic                dp_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                zero
);

  localparam int unsigned   IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                   state, state_n;
  logic [NBYTES-1:0][7:0]   a_q, b_q, res_q;
  logic                     sub_q;
  logic [IW-1:0]            idx;
  logic                     cy;
  logic                     zacc;
  logic                     accept;
  logic                     last;

  assign last   = (idx == LAST);
  assign accept = in_valid && in_ready;
  assign result = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_a      = '0;
    dp_b      = '0;
    dp_m      = 1'b0;
    dp_cin    = 1'b0;
    unique case (state)
      IDLE: begin
        // Held low while reset is asserted so no request is taken during reset.
        in_ready = rst_n;
        if (in_valid && rst_n) state_n = RUN;
      end
      RUN: begin
        dp_a   = a_q[idx];
        dp_b   = b_q[idx];
        dp_m   = sub_q;
        dp_cin = cy;
        if (last) state_n = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      idx       <= '0;
      cy        <= 1'b0;
      zacc      <= 1'b0;
      res_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= op_sub;
      idx   <= '0;
      cy    <= op_sub;
      zacc  <= 1'b1;
    end else if (state == RUN) begin
      res_q[idx] <= dp_sum;
      cy         <= dp_cout;
      // Running zero flag avoids re-reading earlier bytes (works for NBYTES=1 too).
      zacc       <= zacc && (dp_sum == 8'h00);
      if (last) begin
        idx       <= '0;
        carry_out <= dp_cout;
        overflow  <= (a_q[NBYTES-1][7] == (b_q[NBYTES-1][7] ^ sub_q)) &&
                     (dp_sum[7] != a_q[NBYTES-1][7]);
        zero      <= zacc && (dp_sum == 8'h00);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
